// File: rtl/fma16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fma16_pkg : shared types and constants for fma16 / fma16_dot         |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
package fma16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int FLG_NV = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_INF  = 16'h7C00;

endpackage
`default_nettype wire

// File: rtl/fma16_dot_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fma16_dot_if : job control and operand/result streams of fma16_dot   |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
interface fma16_dot_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic [15:0]      init_z;
  logic [1:0]       roundmode;
  logic             negp;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_x;
  logic [15:0]      in_y;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_result;
  logic [3:0]       out_flags;

  modport master (
    output start, len, init_z, roundmode, negp, in_valid, in_x, in_y, out_ready,
    input  busy, in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  start, len, init_z, roundmode, negp, in_valid, in_x, in_y, out_ready,
    output busy, in_ready, out_valid, out_result, out_flags
  );
endinterface
`default_nettype wire

// File: rtl/fma16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fma16 : combinational half-precision fused multiply-add             |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module fma16
  import fma16_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic        mul,
  input  logic        add,
  input  logic        negp,
  input  logic        negz,
  input  logic [1:0]  roundmode,
  output logic [15:0] result,
  output logic [3:0]  flags
);
  localparam int W = 84;

  logic [15:0] w_y, w_z;
  logic        w_sx, w_sy, w_sz, w_sp, w_sr;
  logic [4:0]  w_ex, w_ey, w_ez, w_exx, w_exy, w_exz;
  logic [9:0]  w_fx, w_fy, w_fz;
  logic [10:0] w_mx, w_my, w_mz;
  logic [21:0] w_prod;
  logic [5:0]  w_pshift, w_zshift;
  logic [W-1:0] w_p, w_zv, w_mag;
  logic [6:0]  w_lead, w_lsb, w_base;
  logic [10:0] w_trunc;
  logic        w_guard, w_sticky, w_inc, w_of, w_ovf_inf;
  logic [16:0] w_rnd;
  logic        w_xnan, w_ynan, w_znan, w_xinf, w_yinf, w_zinf, w_xzero, w_yzero;
  logic        w_snan, w_inv, w_pinf;

  assign w_y = mul ? y : FP16_ONE;
  assign w_z = add ? z : FP16_ZERO;
  assign {w_sx, w_ex, w_fx} = x;
  assign {w_ey, w_fy}       = w_y[14:0];
  assign {w_ez, w_fz}       = w_z[14:0];
  assign w_sy = w_y[15];
  assign w_sz = w_z[15] ^ negz;
  assign w_sp = w_sx ^ w_sy ^ negp;

  assign w_xnan  = (&w_ex) & (|w_fx);
  assign w_ynan  = (&w_ey) & (|w_fy);
  assign w_znan  = (&w_ez) & (|w_fz);
  assign w_xinf  = (&w_ex) & ~(|w_fx);
  assign w_yinf  = (&w_ey) & ~(|w_fy);
  assign w_zinf  = (&w_ez) & ~(|w_fz);
  assign w_xzero = ~(|w_ex) & ~(|w_fx);
  assign w_yzero = ~(|w_ey) & ~(|w_fy);
  assign w_snan  = (w_xnan & ~w_fx[9]) | (w_ynan & ~w_fy[9]) | (w_znan & ~w_fz[9]);
  assign w_pinf  = (w_xinf | w_yinf) & ~w_xzero & ~w_yzero & ~w_xnan & ~w_ynan;
  assign w_inv   = w_snan | (w_xinf & w_yzero) | (w_xzero & w_yinf)
                 | (w_pinf & w_zinf & (w_sp != w_sz));

  // Subnormals share the exponent of the smallest normal, minus the hidden bit.
  assign w_mx  = {|w_ex, w_fx};
  assign w_my  = {|w_ey, w_fy};
  assign w_mz  = {|w_ez, w_fz};
  assign w_exx = w_ex | {4'b0, ~(|w_ex)};
  assign w_exy = w_ey | {4'b0, ~(|w_ey)};
  assign w_exz = w_ez | {4'b0, ~(|w_ez)};

  // Exact sum in fixed point with LSB weight 2^-48, so rounding sees every bit.
  assign w_prod   = 22'(w_mx) * 22'(w_my);
  assign w_pshift = {1'b0, w_exx} + {1'b0, w_exy} - 6'd2;
  assign w_zshift = {1'b0, w_exz} + 6'd23;
  assign w_p      = W'(w_prod) << w_pshift;
  assign w_zv     = W'(w_mz) << w_zshift;

  always_comb begin
    w_mag = w_p + w_zv;
    w_sr  = w_sp;
    if (w_sp != w_sz) begin
      if (w_p >= w_zv) begin
        w_mag = w_p - w_zv;
      end else begin
        w_mag = w_zv - w_p;
        w_sr  = w_sz;
      end
    end
  end

  always_comb begin
    w_lead = '0;
    for (int i = 0; i < W; i++) begin
      if (w_mag[i]) w_lead = 7'(i);
    end
  end

  assign w_lsb    = (w_lead > 7'd34) ? w_lead - 7'd10 : 7'd24;
  assign w_base   = (w_lead > 7'd34) ? w_lead - 7'd34 : 7'd0;
  assign w_trunc  = 11'(w_mag >> w_lsb);
  assign w_guard  = w_mag[w_lsb - 7'd1];
  assign w_sticky = |(w_mag & ((W'(1) << (w_lsb - 7'd1)) - W'(1)));

  always_comb begin
    case (roundmode)
      2'b01:   w_inc = w_guard & (w_sticky | w_trunc[0]);
      2'b10:   w_inc = w_sr & (w_guard | w_sticky);
      2'b11:   w_inc = ~w_sr & (w_guard | w_sticky);
      default: w_inc = 1'b0;
    endcase
  end

  // A mantissa carry out of the hidden bit rolls into the exponent field.
  assign w_rnd     = {w_base, 10'b0} + 17'(w_trunc) + 17'(w_inc);
  assign w_of      = (w_rnd >= 17'h7C00);
  assign w_ovf_inf = (roundmode == 2'b01) | ((roundmode == 2'b10) & w_sr)
                   | ((roundmode == 2'b11) & ~w_sr);

  always_comb begin
    result = FP16_ZERO;
    flags  = 4'b0000;
    if (w_inv | w_xnan | w_ynan | w_znan) begin
      result        = 16'h7E00;
      flags[FLG_NV] = w_inv;
    end else if (w_pinf) begin
      result = {w_sp, FP16_INF[14:0]};
    end else if (w_zinf) begin
      result = {w_sz, FP16_INF[14:0]};
    end else if (w_mag == '0) begin
      result = {(w_sp == w_sz) ? w_sp : (roundmode == 2'b10), 15'h0000};
    end else if (w_of) begin
      result        = {w_sr, w_ovf_inf ? FP16_INF[14:0] : 15'h7BFF};
      flags[FLG_OF] = 1'b1;
      flags[FLG_NX] = 1'b1;
    end else begin
      result        = {w_sr, w_rnd[14:0]};
      flags[FLG_NX] = w_guard | w_sticky;
      flags[FLG_UF] = (w_guard | w_sticky) & (w_lead < 7'd34);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fma16_dot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fma16_dot : streaming FP16 dot-product engine around one fma16       |
// | Option    : FMA16_DOT_OUTREG_EN registers fma16 output (WAIT state)  |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module fma16_dot
  import fma16_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  fma16_dot_if.slave      bus
);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_count;
  logic [15:0]      r_acc;
  logic [3:0]       r_flags;
  logic [1:0]       r_rm;
  logic             r_negp;
  logic [15:0]      w_fma_res;
  logic [3:0]       w_fma_flg;
  logic             w_xfer, w_last;

`ifdef FMA16_DOT_OUTREG_EN
  logic [15:0]      r_res_q;
  logic [3:0]       r_flg_q;
`endif

  fma16 u_fma16 (
    .x         (bus.in_x),
    .y         (bus.in_y),
    .z         (r_acc),
    .mul       (1'b1),
    .add       (1'b1),
    .negp      (r_negp),
    .negz      (1'b0),
    .roundmode (r_rm),
    .result    (w_fma_res),
    .flags     (w_fma_flg)
  );

  assign w_xfer = bus.in_valid & (r_state == RUN);
  assign w_last = (r_count == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.start) w_next = (bus.len != '0) ? RUN : DONE;
`ifdef FMA16_DOT_OUTREG_EN
      RUN:  if (w_xfer) w_next = WAIT;
      WAIT: w_next = w_last ? DONE : RUN;
`else
      RUN:  if (w_xfer && w_last) w_next = DONE;
`endif
      DONE: if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (r_state != IDLE);
    bus.in_ready  = (r_state == RUN);
    bus.out_valid = (r_state == DONE);
  end

  assign bus.out_result = r_acc;
  assign bus.out_flags  = r_flags;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
      r_acc   <= FP16_ZERO;
      r_flags <= 4'b0000;
      r_rm    <= 2'b00;
      r_negp  <= 1'b0;
`ifdef FMA16_DOT_OUTREG_EN
      r_res_q <= FP16_ZERO;
      r_flg_q <= 4'b0000;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_count <= bus.len;
            r_rm    <= bus.roundmode;
            r_negp  <= bus.negp;
            r_acc   <= bus.init_z;
            r_flags <= 4'b0000;
          end
        end
        RUN: begin
          if (w_xfer) begin
`ifdef FMA16_DOT_OUTREG_EN
            r_res_q <= w_fma_res;
            r_flg_q <= w_fma_flg;
`else
            r_acc   <= w_fma_res;
            r_flags <= r_flags | w_fma_flg;
            r_count <= r_count - CNT_W'(1);
`endif
          end
        end
`ifdef FMA16_DOT_OUTREG_EN
        WAIT: begin
          r_acc   <= r_res_q;
          r_flags <= r_flags | r_flg_q;
          r_count <= r_count - CNT_W'(1);
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fma16_dot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fma16_dot : directed vector bench for fma16_dot                   |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module tb_fma16_dot;
`ifdef FMA16_DOT_OUTREG_EN
  localparam int C_LAT = 2;
`else
  localparam int C_LAT = 1;
`endif

  typedef struct packed {
    logic [7:0]       len;
    logic [15:0]      iz;
    logic             ng;
    logic [1:0]       rm;
    logic [3:0][15:0] xs;
    logic [3:0][15:0] ys;
    logic [15:0]      er;
    logic [3:0]       ef;
  } vec_t;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[12];

  fma16_dot_if #(.CNT_W(8)) bus ();

  fma16_dot #(.CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic [7:0] len, input logic [15:0] iz, input logic ng,
                              input logic [1:0] rm, input logic [63:0] xs, input logic [63:0] ys,
                              input logic [15:0] er, input logic [3:0] ef);
    vec_t v;
    v.len = len; v.iz = iz; v.ng = ng; v.rm = rm;
    v.xs  = xs;  v.ys = ys; v.er = er; v.ef = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic start_job(input logic [7:0] len, input logic [15:0] iz, input logic ng,
                           input logic [1:0] rm);
    bus.start = 1'b1; bus.len = len; bus.init_z = iz; bus.negp = ng; bus.roundmode = rm;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_pair(input logic [15:0] x, input logic [15:0] y);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1; bus.in_x = x; bus.in_y = y;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("idle_after_accept", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int lat;
    reset = 1'b0;
    bus.start = 1'b0; bus.len = '0; bus.init_z = '0; bus.roundmode = 2'b01; bus.negp = 1'b0;
    bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.out_ready = 1'b0;

    vecs[0]  = mk(8'd3, 16'h0000, 1'b0, 2'b01, 64'h0000_3800_4000_3C00, 64'h0000_4000_4000_4000, 16'h4700, 4'b0000);
    vecs[1]  = mk(8'd2, 16'h4700, 1'b1, 2'b01, 64'h0000_0000_3C00_3C00, 64'h0000_0000_3C00_4000, 16'h4400, 4'b0000);
    vecs[2]  = mk(8'd2, 16'h0000, 1'b0, 2'b01, 64'h0000_0000_3C00_7C00, 64'h0000_0000_3C00_0000, 16'h7E00, 4'b1000);
    vecs[3]  = mk(8'd1, 16'h0000, 1'b0, 2'b01, 64'h3C01, 64'h3C01, 16'h3C02, 4'b0001);
    vecs[4]  = mk(8'd1, 16'h0000, 1'b0, 2'b11, 64'h3C01, 64'h3C01, 16'h3C03, 4'b0001);
    vecs[5]  = mk(8'd1, 16'h0000, 1'b0, 2'b01, 64'h7BFF, 64'h7BFF, 16'h7C00, 4'b0101);
    vecs[6]  = mk(8'd1, 16'h0000, 1'b0, 2'b00, 64'h7BFF, 64'h7BFF, 16'h7BFF, 4'b0101);
    vecs[7]  = mk(8'd1, 16'h3C00, 1'b0, 2'b01, 64'h4000, 64'h4200, 16'h4700, 4'b0000);
    vecs[8]  = mk(8'd1, 16'h4000, 1'b1, 2'b01, 64'h4000, 64'h3C00, 16'h0000, 4'b0000);
    vecs[9]  = mk(8'd1, 16'h4000, 1'b1, 2'b10, 64'h4000, 64'h3C00, 16'h8000, 4'b0000);
    vecs[10] = mk(8'd1, 16'h0000, 1'b0, 2'b01, 64'h0400, 64'h0400, 16'h0000, 4'b0011);
    vecs[11] = mk(8'd1, 16'h0000, 1'b0, 2'b11, 64'h0400, 64'h0400, 16'h0001, 4'b0011);

    repeat (3) @(negedge clk);
    chk("rst_busy",     32'(bus.busy),       32'd0);
    chk("rst_in_ready", 32'(bus.in_ready),   32'd0);
    chk("rst_out_valid",32'(bus.out_valid),  32'd0);
    chk("rst_result",   32'(bus.out_result), 32'h0000);
    chk("rst_flags",    32'(bus.out_flags),  32'h0);
    reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 12; v++) begin
      start_job(vecs[v].len, vecs[v].iz, vecs[v].ng, vecs[v].rm);
      for (int k = 0; k < int'(vecs[v].len); k++) send_pair(vecs[v].xs[k], vecs[v].ys[k]);
      wait_out(lat);
      chk($sformatf("vec%0d_latency", v), 32'(lat), 32'(C_LAT));
      chk($sformatf("vec%0d_result", v), 32'(bus.out_result), 32'(vecs[v].er));
      chk($sformatf("vec%0d_flags", v), 32'(bus.out_flags), 32'(vecs[v].ef));
      drain();
    end

    // Subtract with a three-cycle in_valid gap between terms.
    start_job(8'd2, 16'h4700, 1'b1, 2'b01);
    send_pair(16'h3C00, 16'h4000);
    repeat (3) @(negedge clk);
    chk("gap_busy",      32'(bus.busy),      32'd1);
    chk("gap_out_valid", 32'(bus.out_valid), 32'd0);
    chk("gap_in_ready",  32'(bus.in_ready),  32'd1);
    send_pair(16'h3C00, 16'h3C00);
    wait_out(lat);
    chk("gap_latency", 32'(lat), 32'(C_LAT));
    chk("gap_result",  32'(bus.out_result), 32'h4400);
    chk("gap_flags",   32'(bus.out_flags),  32'h0);
    drain();

    // len=0 held under backpressure while start pulses are ignored.
    start_job(8'd0, 16'h4200, 1'b0, 2'b01);
    chk("len0_valid", 32'(bus.out_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      bus.start = c[0]; bus.len = 8'd5; bus.init_z = 16'h3C00;
      @(negedge clk);
      chk($sformatf("bp%0d_valid", c),  32'(bus.out_valid),  32'd1);
      chk($sformatf("bp%0d_result", c), 32'(bus.out_result), 32'h4200);
      chk($sformatf("bp%0d_flags", c),  32'(bus.out_flags),  32'h0);
    end
    bus.start = 1'b0;
    drain();
    chk("bp_in_ready_idle", 32'(bus.in_ready), 32'd0);

    // Reset mid-job, then a fresh job from its own init_z.
    start_job(8'd3, 16'h3C00, 1'b0, 2'b01);
    send_pair(16'h4000, 16'h4000);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy",      32'(bus.busy),       32'd0);
    chk("mid_rst_in_ready",  32'(bus.in_ready),   32'd0);
    chk("mid_rst_out_valid", 32'(bus.out_valid),  32'd0);
    chk("mid_rst_result",    32'(bus.out_result), 32'h0000);
    chk("mid_rst_flags",     32'(bus.out_flags),  32'h0);
    reset = 1'b1;
    @(negedge clk);
    start_job(8'd1, 16'h4200, 1'b0, 2'b01);
    send_pair(16'h3C00, 16'h3C00);
    wait_out(lat);
    chk("post_rst_latency", 32'(lat), 32'(C_LAT));
    chk("post_rst_result",  32'(bus.out_result), 32'h4400);
    chk("post_rst_flags",   32'(bus.out_flags),  32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
